// File: rtl/alarm_pkg.sv
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared note periods, duration units and player state type
//                for the alarm melody table and the alarm player.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    localparam int NOTE_W = 20;
    localparam int DUR_W  = 5;
    localparam int IDX_W  = 6;

    // Full tone periods in 100 MHz clock cycles
    localparam logic [NOTE_W-1:0] C4 = 20'd382219;
    localparam logic [NOTE_W-1:0] D4 = 20'd340530;
    localparam logic [NOTE_W-1:0] E4 = 20'd303370;
    localparam logic [NOTE_W-1:0] F4 = 20'd286344;
    localparam logic [NOTE_W-1:0] G4 = 20'd255102;
    localparam logic [NOTE_W-1:0] C5 = 20'd191113;
    localparam logic [NOTE_W-1:0] SP = 20'd0;

    // Durations in 0.125 s ticks; FOUR saturates at the largest 5-bit count
    localparam logic [DUR_W-1:0] QUARTER = 5'd2;
    localparam logic [DUR_W-1:0] HALF    = 5'd4;
    localparam logic [DUR_W-1:0] ONE     = 5'd8;
    localparam logic [DUR_W-1:0] TWO     = 5'd16;
    localparam logic [DUR_W-1:0] FOUR    = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } player_state_t;

    // A period of 0 or 1 cannot produce a half-period, so it is a rest
    function automatic logic is_rest(input logic [NOTE_W-1:0] period);
        return (period <= 20'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_player_tone_gen.sv
// ============================================================================
//  Module      : tone_gen
//  Description : Square-wave generator; toggles speaker every period/2 cycles
//                while enabled, silent and cleared on rest or disable.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tone_gen
    import alarm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [19:0]       period,
    output logic              speaker
);

    logic [18:0] w_half;
    logic [18:0] tone_cnt_q, tone_cnt_d;
    logic        speaker_q, speaker_d;

    assign w_half = period[19:1];

    // Half-period counter; speaker flips each time the counter wraps
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        speaker_d  = speaker_q;
        if (!en || is_rest(period)) begin
            tone_cnt_d = '0;
            speaker_d  = 1'b0;
        end else if (tone_cnt_q == w_half - 19'd1) begin
            tone_cnt_d = '0;
            speaker_d  = ~speaker_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 19'd1;
        end
    end

    // Counter and speaker registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            speaker_q  <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            speaker_q  <= speaker_d;
        end
    end

    assign speaker = speaker_q;

endmodule

`default_nettype wire

// File: rtl/alarm_player.sv
// ============================================================================
//  Module      : alarm_player
//  Description : Walks the melody table, latches each note/duration, times
//                the entry in ticks and drives the tone generator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_player
    import alarm_pkg::*;
#(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int SONG_LEN    = 20,
    parameter int LOOP        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [19:0]       note_in,
    input  logic [4:0]        dur_in,
    output logic [5:0]        number_out,
    output logic              speaker,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [5:0]        LAST_IDX  = 6'(SONG_LEN - 1);

    generate
        if (SONG_LEN < 1 || SONG_LEN > 64) begin : g_bad_song_len
            $error("alarm_player: SONG_LEN must be in 1..64");
        end
        if (TICK_CYCLES < 1) begin : g_bad_tick
            $error("alarm_player: TICK_CYCLES must be at least 1");
        end
    endgenerate

    player_state_t     state_q, state_d;
    logic [5:0]        number_q, number_d;
    logic [19:0]       note_q, note_d;
    logic [4:0]        dur_q, dur_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [4:0]        dur_cnt_q, dur_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              w_advance;
    logic              w_tone_en;

    // Next-state: sequencing, entry timing, index advance and abort
    always_comb begin
        state_d   = state_q;
        number_d  = number_q;
        note_d    = note_q;
        dur_d     = dur_q;
        tick_d    = tick_q;
        dur_cnt_d = dur_cnt_q;
        done_d    = 1'b0;
        w_advance = 1'b0;

        case (state_q)
            IDLE: begin
                number_d = '0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                note_d    = note_in;
                dur_d     = dur_in;
                tick_d    = '0;
                dur_cnt_d = '0;
                if (dur_in == 5'd0) begin
                    w_advance = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (dur_cnt_q == dur_q - 5'd1) begin
                        w_advance = 1'b1;
                    end else begin
                        dur_cnt_d = dur_cnt_q + 5'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_advance) begin
            if (number_q < LAST_IDX) begin
                number_d = number_q + 6'd1;
                state_d  = LOAD;
            end else begin
                number_d = '0;
                if (LOOP != 0) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        // Abort overrides everything, including a start in the same cycle
        if (stop) begin
            state_d   = IDLE;
            number_d  = '0;
            tick_d    = '0;
            dur_cnt_d = '0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            number_q  <= '0;
            note_q    <= '0;
            dur_q     <= '0;
            tick_q    <= '0;
            dur_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            number_q  <= number_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            tick_q    <= tick_d;
            dur_cnt_q <= dur_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Tone runs only on edges that stay in PLAY, so leaving PLAY (entry end
    // or abort) lands the speaker at 0 rather than letting it toggle once more
    assign w_tone_en = (state_q == PLAY) && (state_d == PLAY);

    tone_gen u_tone_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_tone_en),
        .period  (note_q),
        .speaker (speaker)
    );

    assign number_out = number_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_player.sv
// ============================================================================
//  Module      : tb_alarm_player
//  Description : Self-checking bench for alarm_player (non-looping and looping
//                instances side by side against an elapsed-cycle model).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_player;
    import alarm_pkg::*;

    localparam int TICK = 4;
    localparam int LEN  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_dur0 = 1'b0;

    logic [19:0] note0, note1;
    logic [4:0]  dur0, dur1;
    logic [5:0]  num0, num1;
    logic        spk0, spk1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    // Elapsed-cycle model: off=0 is the LOAD cycle, off=1..dur*TICK are PLAY
    int m_busy [2];
    int m_idx  [2];
    int m_off  [2];
    int m_done [2];
    int m_note [2];
    int m_dur  [2];

    always #5 clk = ~clk;

    function automatic logic [19:0] tbl_note(input logic [5:0] idx);
        return idx[0] ? SP : 20'd8;
    endfunction

    function automatic logic [4:0] tbl_dur(input logic [5:0] idx, input logic m);
        return (m && idx == 6'd1) ? 5'd0 : 5'd2;
    endfunction

    // Melody table stand-in, combinational on the index each DUT addresses
    always_comb begin
        note0 = tbl_note(num0);
        dur0  = tbl_dur(num0, mode_dur0);
        note1 = tbl_note(num1);
        dur1  = tbl_dur(num1, mode_dur0);
    end

    alarm_player #(.TICK_CYCLES(TICK), .SONG_LEN(LEN), .LOOP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .note_in(note0), .dur_in(dur0), .number_out(num0),
        .speaker(spk0), .busy(busy0), .done(done0)
    );

    alarm_player #(.TICK_CYCLES(TICK), .SONG_LEN(LEN), .LOOP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .note_in(note1), .dur_in(dur1), .number_out(num1),
        .speaker(spk1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic       st;
        logic       sp;
        logic [5:0] num;
        logic       busy;
        logic       done;
        logic       spk;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_idx[d] = 0; m_off[d] = 0;
            m_done[d] = 0; m_note[d] = 0; m_dur[d] = 0;
        end
    endtask

    task automatic model_edge(input logic st, input logic sp);
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 0;
            if (sp) begin
                m_busy[d] = 0; m_idx[d] = 0; m_off[d] = 0;
            end else if (m_busy[d] == 0) begin
                if (st) begin
                    m_busy[d] = 1; m_idx[d] = 0; m_off[d] = 0;
                end
            end else begin
                if (m_off[d] == 0) begin
                    m_note[d] = int'(tbl_note(6'(m_idx[d])));
                    m_dur[d]  = int'(tbl_dur(6'(m_idx[d]), mode_dur0));
                end
                if (m_off[d] == m_dur[d] * TICK) begin
                    m_off[d] = 0;
                    if (m_idx[d] < LEN - 1) begin
                        m_idx[d]++;
                    end else begin
                        m_idx[d] = 0;
                        if (d == 0) begin
                            m_busy[d] = 0;
                            m_done[d] = 1;
                        end
                    end
                end else begin
                    m_off[d]++;
                end
            end
        end
    endtask

    function automatic int exp_spk(input int d);
        if (m_busy[d] != 0 && m_off[d] >= 1 && m_note[d] > 1)
            return ((m_off[d] - 1) / (m_note[d] / 2)) % 2;
        return 0;
    endfunction

    task automatic compare_all();
        chk("d0.number",  32'(num0),  32'(m_idx[0]));
        chk("d0.busy",    32'(busy0), 32'(m_busy[0]));
        chk("d0.done",    32'(done0), 32'(m_done[0]));
        chk("d0.speaker", 32'(spk0),  32'(exp_spk(0)));
        chk("d1.number",  32'(num1),  32'(m_idx[1]));
        chk("d1.busy",    32'(busy1), 32'(m_busy[1]));
        chk("d1.done",    32'(done1), 32'(m_done[1]));
        chk("d1.speaker", 32'(spk1),  32'(exp_spk(1)));
    endtask

    // Apply inputs for one edge, advance the model, compare just after the edge
    task automatic step(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(posedge clk);
        model_edge(st, sp);
        #1;
        compare_all();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    function automatic vec_t mkvec(input logic st, input logic [5:0] num,
                                   input logic b, input logic dn, input logic s);
        vec_t v;
        v.st = st; v.sp = 1'b0; v.num = num; v.busy = b; v.done = dn; v.spk = s;
        return v;
    endfunction

    initial begin
        vec_t vecs [12];
        int   done_cnt;
        int   done_edge;
        int   d1_done;
        int   n;
        int   cnt1;

        // First note: LOAD, 8 PLAY cycles (speaker high for the last 4), then rest
        vecs[0]  = mkvec(1'b1, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) vecs[i] = mkvec(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 5; i <= 8; i++) vecs[i] = mkvec(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        vecs[9]  = mkvec(1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
        vecs[10] = mkvec(1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
        vecs[11] = mkvec(1'b1, 6'd1, 1'b1, 1'b0, 1'b0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.number", 32'(num0), 32'd0);
        chk("reset.speaker", 32'(spk0), 32'd0);
        chk("reset.busy", 32'(busy0), 32'd0);
        chk("reset.done", 32'(done0), 32'd0);
        chk("reset.d1busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;

        // Table-driven first entry
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].st, vecs[i].sp);
            chk($sformatf("t1[%0d].number", i), 32'(num0), 32'(vecs[i].num));
            chk($sformatf("t1[%0d].busy", i), 32'(busy0), 32'(vecs[i].busy));
            chk($sformatf("t1[%0d].done", i), 32'(done0), 32'(vecs[i].done));
            chk($sformatf("t1[%0d].speaker", i), 32'(spk0), 32'(vecs[i].spk));
        end

        // Remainder of the full pass; looping instance wraps at the same edge
        done_cnt = 0; done_edge = 0; d1_done = 0;
        for (int e = 12; e < 60; e++) begin
            step(1'b0, 1'b0);
            if (done0) begin
                done_cnt++;
                done_edge = e + 1;
            end
            if (done1) d1_done++;
            if (e + 1 == 37) begin
                chk("t3.wrap_number", 32'(num1), 32'd0);
                chk("t3.wrap_busy", 32'(busy1), 32'd1);
            end
        end
        chk("t2.done_count", 32'(done_cnt), 32'd1);
        chk("t2.done_edge", 32'(done_edge), 32'd37);
        chk("t2.idle_number", 32'(num0), 32'd0);
        chk("t2.idle_busy", 32'(busy0), 32'd0);
        chk("t3.no_done", 32'(d1_done), 32'd0);
        chk("t3.still_busy", 32'(busy1), 32'd1);

        // Abort mid-PLAY at index 2 while speaker is high, start in same cycle
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n = 0;
        while (num0 != 6'd2 && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t4.reach_idx2", 32'(num0), 32'd2);
        repeat (5) step(1'b0, 1'b0);
        chk("t4.spk_before", 32'(spk0), 32'd1);
        step(1'b1, 1'b1);
        chk("t4.number", 32'(num0), 32'd0);
        chk("t4.busy", 32'(busy0), 32'd0);
        chk("t4.speaker", 32'(spk0), 32'd0);
        chk("t4.done", 32'(done0), 32'd0);
        chk("t4.d1busy", 32'(busy1), 32'd0);
        step(1'b0, 1'b0);
        chk("t4.no_late_done", 32'(done0), 32'd0);

        // Zero-duration entry at index 1 occupies a single LOAD cycle
        mode_dur0 = 1'b1;
        step(1'b1, 1'b0);
        n = 0; cnt1 = 0;
        while (num0 != 6'd2 && n < 50) begin
            step(1'b0, 1'b0);
            n++;
            if (num0 == 6'd1 && busy0) cnt1++;
        end
        chk("t5.reach_idx2", 32'(num0), 32'd2);
        chk("t5.idx1_cycles", 32'(cnt1), 32'd1);
        step(1'b0, 1'b1);
        mode_dur0 = 1'b0;

        // Asynchronous reset while the speaker is high
        step(1'b1, 1'b0);
        n = 0;
        while (!spk0 && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t6.spk_high", 32'(spk0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.speaker", 32'(spk0), 32'd0);
        chk("t6.busy", 32'(busy0), 32'd0);
        chk("t6.number", 32'(num0), 32'd0);
        chk("t6.done", 32'(done0), 32'd0);
        chk("t6.d1busy", 32'(busy1), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk("t6.replay_number", 32'(num0), 32'd0);
        chk("t6.replay_busy", 32'(busy0), 32'd1);

        // Random start/stop pulses and table changes against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(299) == 0) mode_dur0 = ~mode_dur0;
            step(($urandom_range(9) == 0), ($urandom_range(59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
